sync_ram: RTL and testbench



---
 rtl/sync_ram.sv | 61 ++++++
 tb/tb_sync_ram.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram.sv
// sync_ram: single-port synchronous RAM with a registered, write-first read port.
//
// A small scratch store for the datapath. One address serves both reads and
// writes. Read data appears on dout one cycle after the address is presented.
// In a write cycle, dout returns the word being written. A synchronous reset
// clears every word and the output register.
//
// Ports:
//   clk   in   1           rising-edge clock
//   rst   in   1           synchronous active-high reset (clears mem and dout)
//   we    in   1           write enable: store din at mem[addr] this edge
//   addr  in   ADDR_WIDTH  word address for both read and write
//   din   in   DATA_WIDTH  write data
//   dout  out  DATA_WIDTH  registered read data
module sync_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;

  // Next-state: a write updates the addressed word and forwards din to the
  // output register (write-first). Otherwise the output register loads the
  // stored word.
  always_comb begin
    mem_d  = mem_q;
    dout_d = mem_q[addr];
    if (we) begin
      mem_d[addr] = din;
      dout_d      = din;
    end
  end

  // Reset takes priority over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_sync_ram.sv
module tb_sync_ram;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;

  int errors;
  int checks;

  sync_ram #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs on the falling edge, then move to just after
  // the following rising edge so dout reflects that edge.
  task automatic step(input logic r, input logic w, input logic [1:0] a,
                      input logic [15:0] d);
    @(negedge clk);
    rst  = r;
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 2'd0, 16'h0000);
    step(1'b1, 1'b0, 2'd0, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dout: dout=%h expected=%h", dout, 16'h0000);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 2'(i), 16'hFFFF);
      checks++;
      if (dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read_addr%0d: dout=%h expected=%h", i, dout, 16'h0000);
      end
    end
  endtask

  task automatic test_write_read;
    step(1'b0, 1'b1, 2'd2, 16'h0009);
    checks++;
    if (dout !== 16'h0009) begin
      errors++;
      $display("FAIL write2_through: dout=%h expected=%h", dout, 16'h0009);
    end
    step(1'b0, 1'b0, 2'd2, 16'h0000);
    checks++;
    if (dout !== 16'h0009) begin
      errors++;
      $display("FAIL read2: dout=%h expected=%h", dout, 16'h0009);
    end
  endtask

  task automatic test_isolation;
    step(1'b0, 1'b1, 2'd3, 16'h000D);
    checks++;
    if (dout !== 16'h000D) begin
      errors++;
      $display("FAIL write3_through: dout=%h expected=%h", dout, 16'h000D);
    end
    step(1'b0, 1'b0, 2'd3, 16'h0000);
    checks++;
    if (dout !== 16'h000D) begin
      errors++;
      $display("FAIL read3: dout=%h expected=%h", dout, 16'h000D);
    end
    step(1'b0, 1'b0, 2'd2, 16'h0000);
    checks++;
    if (dout !== 16'h0009) begin
      errors++;
      $display("FAIL read2_isolated: dout=%h expected=%h", dout, 16'h0009);
    end
    step(1'b0, 1'b0, 2'd0, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL read0_unwritten: dout=%h expected=%h", dout, 16'h0000);
    end
  endtask

  task automatic test_overwrite;
    step(1'b0, 1'b1, 2'd1, 16'hFFFF);
    checks++;
    if (dout !== 16'hFFFF) begin
      errors++;
      $display("FAIL write1_first: dout=%h expected=%h", dout, 16'hFFFF);
    end
    step(1'b0, 1'b1, 2'd1, 16'hA5A5);
    checks++;
    if (dout !== 16'hA5A5) begin
      errors++;
      $display("FAIL write1_second: dout=%h expected=%h", dout, 16'hA5A5);
    end
    step(1'b0, 1'b0, 2'd0, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL read0_after_w1: dout=%h expected=%h", dout, 16'h0000);
    end
    step(1'b0, 1'b0, 2'd1, 16'h0000);
    checks++;
    if (dout !== 16'hA5A5) begin
      errors++;
      $display("FAIL read1_last_wins: dout=%h expected=%h", dout, 16'hA5A5);
    end
  endtask

  // dout must hold between edges even while inputs change.
  task automatic test_hold;
    step(1'b0, 1'b0, 2'd3, 16'h0000);
    @(negedge clk);
    addr = 2'd2;
    we   = 1'b1;
    din  = 16'h7777;
    #2;
    checks++;
    if (dout !== 16'h000D) begin
      errors++;
      $display("FAIL hold_between_edges: dout=%h expected=%h", dout, 16'h000D);
    end
    we = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 16'h0009) begin
      errors++;
      $display("FAIL hold_then_read2: dout=%h expected=%h", dout, 16'h0009);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  seq_a [3];
    logic [15:0] seq_e [3];
    seq_a[0] = 2'd3; seq_e[0] = 16'h000D;
    seq_a[1] = 2'd2; seq_e[1] = 16'h0009;
    seq_a[2] = 2'd3; seq_e[2] = 16'h000D;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, seq_a[i], 16'h0000);
      checks++;
      if (dout !== seq_e[i]) begin
        errors++;
        $display("FAIL b2b_read%0d: dout=%h expected=%h", i, dout, seq_e[i]);
      end
    end
  endtask

  task automatic test_reset_beats_write;
    step(1'b1, 1'b1, 2'd0, 16'h1234);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL rst_with_write_dout: dout=%h expected=%h", dout, 16'h0000);
    end
    step(1'b0, 1'b0, 2'd0, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL rst_discards_write0: dout=%h expected=%h", dout, 16'h0000);
    end
    step(1'b0, 1'b0, 2'd3, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL rst_clears3: dout=%h expected=%h", dout, 16'h0000);
    end
    step(1'b0, 1'b0, 2'd1, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL rst_clears1: dout=%h expected=%h", dout, 16'h0000);
    end
    step(1'b0, 1'b1, 2'd0, 16'h55AA);
    checks++;
    if (dout !== 16'h55AA) begin
      errors++;
      $display("FAIL first_write_after_rst: dout=%h expected=%h", dout, 16'h55AA);
    end
    step(1'b0, 1'b0, 2'd2, 16'h0000);
    step(1'b0, 1'b0, 2'd0, 16'h0000);
    checks++;
    if (dout !== 16'h55AA) begin
      errors++;
      $display("FAIL read0_after_rst_write: dout=%h expected=%h", dout, 16'h55AA);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    din  = 16'h0000;
    test_reset();
    test_write_read();
    test_isolation();
    test_overwrite();
    test_hold();
    test_back_to_back();
    test_reset_beats_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
